// File: rtl/operand_pkg.sv
// rtl/operand_pkg.sv - shared operand types for the operand pair buffer
package operand_pkg;

    localparam int OP_W = 5;

    typedef logic [OP_W-1:0] op_t;

    typedef struct packed {
        op_t a;
        op_t b;
    } op_pair_t;

endpackage

// File: rtl/pair_fifo_mem.sv
// rtl/pair_fifo_mem.sv - DEPTH x DW storage array, one write port and one async read port
module pair_fifo_mem #(
    parameter int DW    = 10,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    // Storage is deliberately left unreset; validity is tracked by the owner's count.
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/operand_pair_fifo.sv
// rtl/operand_pair_fifo.sv - operand pair FIFO with registered head slot and input protocol monitor
module operand_pair_fifo
    import operand_pkg::*;
#(
    parameter int WIDTH = OP_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_op_a,
    input  logic [WIDTH-1:0] s_op_b,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_op_a,
    output logic [WIDTH-1:0] m_op_b,
    output logic [CNT_W-1:0] count,
    input  logic             err_clr,
    output logic             proto_err
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               s_ready_q, s_ready_d;
    logic               m_valid_q, m_valid_d;
    logic [WIDTH-1:0]   head_a_q, head_a_d;
    logic [WIDTH-1:0]   head_b_q, head_b_d;
    logic               stall_q, stall_d;
    logic [WIDTH-1:0]   held_a_q, held_b_q;
    logic               err_q, err_d;
    logic               push, pop, head_load, bypass, violation;
    logic [2*WIDTH-1:0] rd_pair;

    pair_fifo_mem #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i ({s_op_a, s_op_b}),
        .raddr_i (rptr_d),
        .rdata_o (rd_pair)
    );

    // The head slot mirrors the entry at rptr; it is refilled whenever it is empty or being popped.
    always_comb begin
        push      = s_valid & s_ready_q;
        pop       = m_valid_q & m_ready;
        wptr_d    = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d    = pop  ? ptr_inc(rptr_q) : rptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        s_ready_d = (count_d < FULL_CNT);
        m_valid_d = (count_d != '0);
        head_load = (!m_valid_q || pop) && (count_d != '0);
        // Nothing older is left in storage, so the incoming pair becomes the head directly.
        bypass    = (count_q == '0) || (pop && (count_q == CNT_W'(1)));
        head_a_d  = head_a_q;
        head_b_d  = head_b_q;
        if (head_load) begin
            if (bypass) begin
                head_a_d = s_op_a;
                head_b_d = s_op_b;
            end else begin
                head_a_d = rd_pair[2*WIDTH-1:WIDTH];
                head_b_d = rd_pair[WIDTH-1:0];
            end
        end
        stall_d   = s_valid & ~s_ready_q;
        violation = stall_q & (~s_valid | (s_op_a != held_a_q) | (s_op_b != held_b_q));
        err_d     = violation ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            head_a_q  <= '0;
            head_b_q  <= '0;
            stall_q   <= 1'b0;
            held_a_q  <= '0;
            held_b_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            head_a_q  <= head_a_d;
            head_b_q  <= head_b_d;
            stall_q   <= stall_d;
            held_a_q  <= s_op_a;
            held_b_q  <= s_op_b;
            err_q     <= err_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_op_a    = head_a_q;
    assign m_op_b    = head_b_q;
    assign count     = count_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_operand_pair_fifo.sv
// tb/tb_operand_pair_fifo.sv - scoreboard bench for operand_pair_fifo
module tb_operand_pair_fifo;
    import operand_pkg::*;

    localparam int WIDTH = OP_W;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid, s_ready, m_valid, m_ready, err_clr, proto_err;
    logic [WIDTH-1:0] s_op_a, s_op_b, m_op_a, m_op_b;
    logic [CNT_W-1:0] count;

    int       checks   = 0;
    int       failures = 0;
    int       n_pops   = 0;
    op_pair_t exp_q[$];

    operand_pair_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_op_a    (s_op_a),
        .s_op_b    (s_op_b),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_op_a    (m_op_a),
        .m_op_b    (m_op_b),
        .count     (count),
        .err_clr   (err_clr),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        s_valid = 1'b1;
        s_op_a  = a;
        s_op_b  = b;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (m_valid !== 1'b1) break;
            tick();
        end
        m_ready = 1'b0;
        chk("drain_done", {31'd0, m_valid}, 32'd0);
    endtask

    // Scoreboard: capture accepted offers, compare every presented pair the consumer takes.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    op_pair_t e;
                    e = exp_q.pop_front();
                    chk("sb_op_a", {27'd0, m_op_a}, {27'd0, e.a});
                    chk("sb_op_b", {27'd0, m_op_b}, {27'd0, e.b});
                end
            end
            if (s_valid === 1'b1 && s_ready === 1'b1) begin
                exp_q.push_back('{a: s_op_a, b: s_op_b});
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_op_a  = '0;
        s_op_b  = '0;
        m_ready = 1'b0;
        err_clr = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_s_ready", {31'd0, s_ready}, 32'd1);
        chk("idle_m_valid", {31'd0, m_valid}, 32'd0);
        chk("idle_op_a", {27'd0, m_op_a}, 32'd0);
        chk("idle_op_b", {27'd0, m_op_b}, 32'd0);

        // Single push, head held stable while consumer stalls
        offer(5'h03, 5'h1C);
        tick();
        s_valid = 1'b0;
        chk("one_m_valid", {31'd0, m_valid}, 32'd1);
        chk("one_op_a", {27'd0, m_op_a}, 32'h03);
        chk("one_op_b", {27'd0, m_op_b}, 32'h1C);
        chk("one_count", {29'd0, count}, 32'd1);
        tick();
        tick();
        chk("one_stable_a", {27'd0, m_op_a}, 32'h03);
        chk("one_stable_b", {27'd0, m_op_b}, 32'h1C);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("last_pop_valid", {31'd0, m_valid}, 32'd0);
        chk("last_pop_count", {29'd0, count}, 32'd0);
        chk("last_pop_hold_a", {27'd0, m_op_a}, 32'h03);

        // Fill to full, then a 5th offer waits one cycle past a pop
        for (int i = 0; i < 4; i++) begin
            offer(5'(2 * i + 1), 5'(2 * i + 2));
            tick();
        end
        offer(5'h09, 5'h0A);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_s_ready", {31'd0, s_ready}, 32'd0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("pop_full_count", {29'd0, count}, 32'd3);
        chk("pop_full_s_ready", {31'd0, s_ready}, 32'd1);
        chk("pop_full_head", {27'd0, m_op_a}, 32'h03);
        tick();
        s_valid = 1'b0;
        chk("refill_count", {29'd0, count}, 32'd4);
        drain();
        chk("held_offer_no_err", {31'd0, proto_err}, 32'd0);

        // Streaming: pointers wrap several times at occupancy 1
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            offer(5'(i), 5'(i));
            tick();
            if (i == 1 || i == 7 || i == 19)
                chk($sformatf("stream_count_%0d", i), {29'd0, count}, 32'd1);
        end
        s_valid = 1'b0;
        drain();
        chk("stream_no_err", {31'd0, proto_err}, 32'd0);

        // Protocol error: unstable offer while full, then clear priority
        for (int i = 0; i < 4; i++) begin
            offer(5'(8'h11 + i), 5'(8'h11 + i));
            tick();
        end
        offer(5'h0A, 5'h0A);
        tick();
        chk("stall_no_err", {31'd0, proto_err}, 32'd0);
        s_op_a = 5'h0B;
        tick();
        chk("err_set", {31'd0, proto_err}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", {31'd0, proto_err}, 32'd0);
        s_op_a  = 5'h0C;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_set_beats_clr", {31'd0, proto_err}, 32'd1);
        s_valid = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr2", {31'd0, proto_err}, 32'd0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("three_held", {29'd0, count}, 32'd3);

        // Asynchronous reset mid-stream discards everything held
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", {29'd0, count}, 32'd0);
        chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", {31'd0, m_valid}, 32'd0);
        offer(5'h15, 5'h16);
        tick();
        s_valid = 1'b0;
        chk("post_rst_valid", {31'd0, m_valid}, 32'd1);
        chk("post_rst_a", {27'd0, m_op_a}, 32'h15);
        chk("post_rst_b", {27'd0, m_op_b}, 32'h16);
        chk("post_rst_count", {29'd0, count}, 32'd1);
        drain();

        tick();
        chk("sb_empty", exp_q.size(), 32'd0);
        chk("pop_total", n_pops, 32'd28);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/operand_pair_fifo.md
Name: operand_pair_fifo

Overview:
- Buffers operand pairs (A, B) upstream of the 5-bit combinational AND/OR/ADD datapath cluster.
- Presents one pair at a time on stable, registered outputs that drive the datapath's two operand inputs.
- Decouples a bursty producer from the consumer using valid/ready handshakes on both sides.
- Adds a sticky protocol-error monitor on the input side.

Parameters:
- WIDTH, 5, bit width of each operand (matches the datapath operand width).
- DEPTH, 4, number of stored pairs; any value >= 2 (need not be a power of two).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  Sole clock; everything samples on the rising edge.
- rst_n  in  1  Reset; asynchronous assert, active-low.
- s_valid  in  1  Producer has a pair on s_op_a/s_op_b.
- s_ready  out  1  FIFO can accept a pair this cycle.
- s_op_a  in  WIDTH  Operand A from producer.
- s_op_b  in  WIDTH  Operand B from producer.
- m_valid  out  1  m_op_a/m_op_b hold a valid pair.
- m_ready  in  1  Consumer takes the pair this cycle.
- m_op_a  out  WIDTH  Operand A to the datapath in_0 input.
- m_op_b  out  WIDTH  Operand B to the datapath in_1 input.
- count  out  CNT_W  Number of pairs held, including the one presented.
- err_clr  in  1  Synchronous clear of proto_err.
- proto_err  out  1  Sticky input-protocol violation flag.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release): pointers 0, count 0, m_valid 0, m_op_a/m_op_b 0, proto_err 0, s_ready 0 while rst_n low. Reset mid-burst discards all held pairs; no partial pair survives.
- Push = s_valid & s_ready. Pop = m_valid & m_ready.
- s_ready = (count < DEPTH), driven from a register. No combinational path from m_ready: when full, a same-cycle pop does not enable a push.
- Write pointer and read pointer each wrap DEPTH-1 -> 0.
- Output stage is a registered head slot (first-word-fall-through). Latency from a push into an empty FIFO to m_valid = 1 cycle. A push and a pop in the same cycle into a 1-entry FIFO loads the new pair into the head next cycle, so m_valid stays 1.
- m_op_a/m_op_b are stable while m_valid & !m_ready. After the final pop they hold their last value and m_valid = 0.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- Empty: m_valid = 0; m_ready is ignored.
- proto_err sets when, in the cycle after s_valid & !s_ready, either s_valid falls or s_op_a/s_op_b change (a dropped or unstable offer).
- proto_err stays set until err_clr. Set has priority over err_clr in the same cycle.
- Data is unmodified; no arithmetic is done here. Pairs leave in push order.

Decomposition:
- Shared package operand_pkg holds:
  - localparam OP_W = 5
  - typedef logic [OP_W-1:0] op_t
  - typedef struct packed {op_t a; op_t b;} op_pair_t
- Ports carry op_pair_t fields.
- One natural sub-module: pair_fifo_mem, the DEPTH x (2*WIDTH) register array. It has a write port (we, waddr, wdata) and an async read port (raddr, rdata), with no reset on storage.
- Pointer, count, head and error logic stay in the top module.

Test Plan:
- Reset then idle -> m_valid 0, count 0, s_ready 1 one cycle after rst_n rises; m_op_a/b = 0.
- Push (A=5'h03, B=5'h1C) into empty FIFO, m_ready 0 -> m_valid 1 next cycle with m_op_a 03 / m_op_b 1C held stable; count 1.
- Push 4 pairs (01/02, 03/04, 05/06, 07/08) with m_ready 0 -> count 4, s_ready 0. A 5th offer (09/0A) held with m_ready=1 for one cycle -> 01/02 pops, 09/0A is not accepted that cycle and is accepted the next; final pop order is 01,03,05,07,09.
- Continuous push and pop with s_valid=m_ready=1 over 20 pairs (values 0..19) -> count steady at 1, every pair out in order, pointers wrap without loss.
- While full, s_valid held and s_op_a changes 0A->0B -> proto_err 1 next cycle. err_clr pulse -> 0. err_clr asserted in the same cycle as a new violation -> stays 1.
- rst_n dropped asynchronously with 3 pairs held -> m_valid and count go to 0 immediately. After release, the next push appears alone with latency 1.
